// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, shared-ALU and response signals of the two-requester ALU arbiter
interface alu_arbiter_if;
    logic        req0_valid_in, req1_valid_in;
    logic        req0_ready_out, req1_ready_out;
    logic [6:0]  req0_opcode_in, req1_opcode_in, req0_funct7_in, req1_funct7_in;
    logic [2:0]  req0_funct3_in, req1_funct3_in;
    logic [31:0] req0_rs1_in, req1_rs1_in, req0_rs2_in, req1_rs2_in, req0_imm_in, req1_imm_in;
    logic [6:0]  alu_opcode_out, alu_funct7_out;
    logic [2:0]  alu_funct3_out;
    logic [31:0] alu_rs1_out, alu_rs2_out, alu_imm_out;
    logic [31:0] alu_result_in;
    logic        alu_non_zero_in;
    logic        rsp0_valid_out, rsp1_valid_out;
    logic        rsp0_ready_in, rsp1_ready_in;
    logic [31:0] rsp_result_out;
    logic        rsp_non_zero_out, rsp_illegal_out;

    modport slave (
        input  req0_valid_in, req1_valid_in,
        input  req0_opcode_in, req1_opcode_in, req0_funct7_in, req1_funct7_in,
        input  req0_funct3_in, req1_funct3_in,
        input  req0_rs1_in, req1_rs1_in, req0_rs2_in, req1_rs2_in, req0_imm_in, req1_imm_in,
        output req0_ready_out, req1_ready_out,
        output alu_opcode_out, alu_funct7_out, alu_funct3_out, alu_rs1_out, alu_rs2_out, alu_imm_out,
        input  alu_result_in, alu_non_zero_in,
        output rsp0_valid_out, rsp1_valid_out,
        input  rsp0_ready_in, rsp1_ready_in,
        output rsp_result_out, rsp_non_zero_out, rsp_illegal_out
    );

    modport master (
        output req0_valid_in, req1_valid_in,
        output req0_opcode_in, req1_opcode_in, req0_funct7_in, req1_funct7_in,
        output req0_funct3_in, req1_funct3_in,
        output req0_rs1_in, req1_rs1_in, req0_rs2_in, req1_rs2_in, req0_imm_in, req1_imm_in,
        input  req0_ready_out, req1_ready_out,
        input  alu_opcode_out, alu_funct7_out, alu_funct3_out, alu_rs1_out, alu_rs2_out, alu_imm_out,
        output alu_result_in, alu_non_zero_in,
        input  rsp0_valid_out, rsp1_valid_out,
        output rsp0_ready_in, rsp1_ready_in,
        input  rsp_result_out, rsp_non_zero_out, rsp_illegal_out
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one operation in flight,
// requester 0 preferred with a starvation bound for requester 1.
module alu_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  skip_cnt;
    logic        id, grant1, accept, rsp_ready, legal;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, imm, rsp_result;
    logic        rsp_nz, rsp_ill;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        grant1    = bus.req1_valid_in && (!bus.req0_valid_in || skip_cnt == 4'(STARVE_LIMIT));
        accept    = state == IDLE && (bus.req0_valid_in || bus.req1_valid_in);
        rsp_ready = id ? bus.rsp1_ready_in : bus.rsp0_ready_in;
        legal     = opcode == 7'b0110011 || opcode == 7'b0010011;
        state_nx  = accept ? EXEC : state == EXEC ? RESP : (state == RESP && rsp_ready) ? IDLE : state;
        // ready is combinational on valid, so gate it with reset to keep it low while held in reset
        bus.req0_ready_out = reset_n && state == IDLE && bus.req0_valid_in && !grant1;
        bus.req1_ready_out = reset_n && state == IDLE && grant1;
        bus.rsp0_valid_out = state == RESP && !id;
        bus.rsp1_valid_out = state == RESP && id;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            skip_cnt   <= '0;
            id         <= 1'b0;
            opcode     <= '0;
            funct3     <= '0;
            funct7     <= '0;
            rs1        <= '0;
            rs2        <= '0;
            imm        <= '0;
            rsp_result <= '0;
            rsp_nz     <= 1'b0;
            rsp_ill    <= 1'b0;
        end else begin
            if (accept) begin
                id       <= grant1;
                opcode   <= grant1 ? bus.req1_opcode_in : bus.req0_opcode_in;
                funct3   <= grant1 ? bus.req1_funct3_in : bus.req0_funct3_in;
                funct7   <= grant1 ? bus.req1_funct7_in : bus.req0_funct7_in;
                rs1      <= grant1 ? bus.req1_rs1_in : bus.req0_rs1_in;
                rs2      <= grant1 ? bus.req1_rs2_in : bus.req0_rs2_in;
                imm      <= grant1 ? bus.req1_imm_in : bus.req0_imm_in;
                skip_cnt <= grant1 ? 4'd0 : bus.req1_valid_in ? skip_cnt + 4'd1 : skip_cnt;
            end
            if (state == EXEC) begin
                rsp_result <= legal ? bus.alu_result_in : 32'd0;
                rsp_nz     <= legal && bus.alu_non_zero_in;
                rsp_ill    <= !legal;
            end
        end

    assign bus.alu_opcode_out   = opcode;
    assign bus.alu_funct3_out   = funct3;
    assign bus.alu_funct7_out   = funct7;
    assign bus.alu_rs1_out      = rs1;
    assign bus.alu_rs2_out      = rs2;
    assign bus.alu_imm_out      = imm;
    assign bus.rsp_result_out   = rsp_result;
    assign bus.rsp_non_zero_out = rsp_nz;
    assign bus.rsp_illegal_out  = rsp_ill;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed stimulus against a transaction-level model of the arbiter,
// with a small RISC-V style ALU standing in for the shared ALU.
module tb_alu_arbiter;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1, rs2, imm;
    } desc_t;

    logic clk = 0, reset_n = 1;
    int   total = 0, bad = 0;
    always #5 clk = ~clk;

    alu_arbiter_if bus();
    alu_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    function automatic logic [31:0] alu_f(desc_t d);
        logic [31:0] b = d.op == 7'b0010011 ? d.imm : d.rs2;
        case (d.f3)
            3'd0: return (d.op == 7'b0110011 && d.f7[5]) ? d.rs1 - b : d.rs1 + b;
            3'd1: return d.rs1 << b[4:0];
            3'd2: return {31'd0, $signed(d.rs1) < $signed(b)};
            3'd3: return {31'd0, d.rs1 < b};
            3'd4: return d.rs1 ^ b;
            3'd5: return d.f7[5] ? 32'($signed(d.rs1) >>> b[4:0]) : d.rs1 >> b[4:0];
            3'd6: return d.rs1 | b;
            default: return d.rs1 & b;
        endcase
    endfunction

    desc_t alu_d;
    assign alu_d = {bus.alu_opcode_out, bus.alu_funct3_out, bus.alu_funct7_out,
                    bus.alu_rs1_out, bus.alu_rs2_out, bus.alu_imm_out};
    assign bus.alu_result_in   = alu_f(alu_d);
    assign bus.alu_non_zero_in = bus.alu_result_in != 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: age -1 = no operation, 0 = executing, >=1 = response offered
    int    age = -1, m_skip = 0;
    logic  m_id = 0, m_nz = 0, m_ill = 0;
    desc_t m_desc = '0;
    logic [31:0] m_res = 0;
    int    grants[$];

    function automatic logic pick1();
        return bus.req1_valid_in && (!bus.req0_valid_in || m_skip == LIMIT);
    endfunction

    function automatic desc_t req_desc(logic n);
        return n ? desc_t'({bus.req1_opcode_in, bus.req1_funct3_in, bus.req1_funct7_in,
                            bus.req1_rs1_in, bus.req1_rs2_in, bus.req1_imm_in})
                 : desc_t'({bus.req0_opcode_in, bus.req0_funct3_in, bus.req0_funct7_in,
                            bus.req0_rs1_in, bus.req0_rs2_in, bus.req0_imm_in});
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age = -1; m_skip = 0; m_id = 0; m_desc = '0; m_res = 0; m_nz = 0; m_ill = 0;
        end else if (age < 0) begin
            if (bus.req0_valid_in || bus.req1_valid_in) begin
                m_id = pick1();
                m_desc = req_desc(m_id);
                grants.push_back(int'(m_id));
                m_skip = m_id ? 0 : bus.req1_valid_in ? m_skip + 1 : m_skip;
                age = 0;
            end
        end else if (age == 0) begin
            m_ill = !(m_desc.op == 7'b0110011 || m_desc.op == 7'b0010011);
            m_res = m_ill ? 32'd0 : alu_f(m_desc);
            m_nz  = m_res != 0;
            age = 1;
        end else if (m_id ? bus.rsp1_ready_in : bus.rsp0_ready_in) age = -1;
        else age++;
    end

    always @(negedge clk) begin
        chk("ready0", bus.req0_ready_out, reset_n && age < 0 && bus.req0_valid_in && !pick1());
        chk("ready1", bus.req1_ready_out, reset_n && age < 0 && pick1());
        chk("rsp0_valid", bus.rsp0_valid_out, age >= 1 && !m_id);
        chk("rsp1_valid", bus.rsp1_valid_out, age >= 1 && m_id);
        chk("alu_desc", alu_d, m_desc);
        chk("rsp_result", bus.rsp_result_out, m_res);
        chk("rsp_non_zero", bus.rsp_non_zero_out, m_nz);
        chk("rsp_illegal", bus.rsp_illegal_out, m_ill);
    end

    function automatic desc_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                 logic [31:0] a, logic [31:0] b, logic [31:0] i);
        return '{op: op, f3: f3, f7: f7, rs1: a, rs2: b, imm: i};
    endfunction

    function automatic desc_t rnd_desc();
        logic [6:0]  op = $urandom_range(0, 3) == 0 ? 7'($urandom) :
                          $urandom_range(0, 1) ? 7'b0110011 : 7'b0010011;
        logic [31:0] a = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
        return mk(op, 3'($urandom), $urandom_range(0, 1) ? 7'h20 : 7'h00, a,
                  $urandom_range(0, 1) ? a : $urandom, $urandom_range(0, 1) ? 32'd0 : $urandom);
    endfunction

    task automatic set_req(logic n, desc_t d, logic v);
        if (n) begin
            bus.req1_valid_in = v; {bus.req1_opcode_in, bus.req1_funct3_in, bus.req1_funct7_in,
                                    bus.req1_rs1_in, bus.req1_rs2_in, bus.req1_imm_in} = d;
        end else begin
            bus.req0_valid_in = v; {bus.req0_opcode_in, bus.req0_funct3_in, bus.req0_funct7_in,
                                    bus.req0_rs1_in, bus.req0_rs2_in, bus.req0_imm_in} = d;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(string nm, logic n, desc_t d, logic [31:0] er, logic enz, logic eill);
        set_req(n, d, 1);
        set_req(!n, rnd_desc(), 0);
        @(negedge clk);
        chk({nm, "_ready"}, n ? bus.req1_ready_out : bus.req0_ready_out, 1);
        cyc();
        set_req(n, d, 0);
        @(negedge clk);
        chk({nm, "_alu"}, alu_d, d);
        chk({nm, "_early_valid"}, bus.rsp0_valid_out | bus.rsp1_valid_out, 0);
        cyc();
        @(negedge clk);
        chk({nm, "_valid"}, {bus.rsp1_valid_out, bus.rsp0_valid_out}, n ? 2'b10 : 2'b01);
        chk({nm, "_result"}, bus.rsp_result_out, er);
        chk({nm, "_non_zero"}, bus.rsp_non_zero_out, enz);
        chk({nm, "_illegal"}, bus.rsp_illegal_out, eill);
        cyc();
    endtask

    task automatic wait_grants(string nm, int n, int exp[]);
        for (int i = 0; i < 100 && grants.size() < n; i++) cyc();
        chk({nm, "_count"}, grants.size(), n);
        for (int i = 0; i < n && i < grants.size(); i++) chk({nm, "_order"}, grants[i], exp[i]);
    endtask

    initial begin
        set_req(0, mk(7'b0110011, 0, 0, 1, 2, 0), 1);
        set_req(1, '0, 0);
        bus.rsp0_ready_in = 1;
        bus.rsp1_ready_in = 1;
        #1 reset_n = 0;
        #1;
        chk("rst_ready0", bus.req0_ready_out, 0);
        chk("rst_outputs", {bus.rsp0_valid_out, bus.rsp1_valid_out, bus.rsp_result_out, alu_d}, 0);
        repeat (2) cyc();
        set_req(0, '0, 0);
        reset_n = 1;
        cyc();

        run_op("add", 0, mk(7'b0110011, 3'b000, 7'h00, 5, 7, 0), 12, 1, 0);
        run_op("illegal", 1, mk(7'b0000011, 3'b010, 7'h00, 3, 0, 4), 0, 0, 1);
        run_op("sub_zero", 0, mk(7'b0110011, 3'b000, 7'h20, 9, 9, 0), 0, 0, 0);
        run_op("addi", 1, mk(7'b0010011, 3'b000, 7'h00, 40, 0, 2), 42, 1, 0);

        grants.delete();
        set_req(0, mk(7'b0110011, 3'd4, 0, 6, 3, 0), 1);
        set_req(1, mk(7'b0010011, 3'd6, 0, 8, 0, 1), 1);
        wait_grants("starve", 10, '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
        set_req(0, '0, 0);
        set_req(1, '0, 0);
        repeat (4) cyc();

        set_req(1, mk(7'b0110011, 3'b000, 7'h00, 100, 23, 0), 1);
        bus.rsp1_ready_in = 0;
        @(negedge clk);
        chk("hold_ready1", bus.req1_ready_out, 1);
        cyc();
        set_req(1, '0, 0);
        cyc();
        set_req(0, mk(7'b0110011, 3'b111, 0, 5, 3, 0), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid1", bus.rsp1_valid_out, 1);
            chk("hold_readys", {bus.req0_ready_out, bus.req1_ready_out, bus.rsp0_valid_out}, 0);
            chk("hold_result", bus.rsp_result_out, 123);
            cyc();
        end
        set_req(0, '0, 0);
        bus.rsp1_ready_in = 1;
        @(negedge clk);
        chk("release_valid1", bus.rsp1_valid_out, 1);
        cyc();
        @(negedge clk);
        chk("after_release", bus.rsp1_valid_out, 0);

        set_req(0, mk(7'b0110011, 3'b000, 0, 1, 1, 0), 1);
        set_req(1, mk(7'b0110011, 3'b110, 0, 2, 4, 0), 1);
        cyc();
        #1 reset_n = 0;
        #1;
        chk("rst_exec_ready", {bus.req0_ready_out, bus.req1_ready_out}, 0);
        chk("rst_exec_outputs", {bus.rsp0_valid_out, bus.rsp1_valid_out, bus.rsp_result_out,
                                 bus.rsp_non_zero_out, bus.rsp_illegal_out, alu_d}, 0);
        grants.delete();
        cyc();
        reset_n = 1;
        wait_grants("post_reset", 5, '{0, 0, 0, 0, 1});

        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset_n = $urandom_range(0, 299) != 0;
            set_req(0, rnd_desc(), $urandom_range(0, 1));
            set_req(1, rnd_desc(), $urandom_range(0, 1));
            bus.rsp0_ready_in = $urandom_range(0, 2) != 0;
            bus.rsp1_ready_in = $urandom_range(0, 2) != 0;
        end
        reset_n = 1;
        set_req(0, '0, 0);
        set_req(1, '0, 0);
        repeat (5) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
